// File: rtl/time_counter.sv
// Time-of-day counter: a CLK_FREQ prescaler drives an HH:MM:SS register with a freeze mode and edge-triggered loading.
// Define CHASY_LOAD_CHECK_EN to reject out-of-range loads with a load_err pulse; by default bad fields load as zero.
module time_counter #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  rezhim,
  input  logic [23:0] setup_data,
  input  logic        setup_imp,
  output logic [23:0] data_ch,
  output logic        sec_tick,
  output logic        load_err
);

  localparam int              PW         = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_FREQ - 1);
  localparam logic [1:0]      MODE_SETUP = 2'd3;

  logic [PW-1:0] presc;
  logic          setup_prev;
  logic          freeze;
  logic          load_ev;
  logic          load_apply;
  logic          count_en;
  logic          tick_due;
  logic [23:0]   load_val;
  logic [23:0]   time_next;
  logic [7:0]    sec_cur, min_cur, hour_cur;
  logic [7:0]    sec_in, min_in, hour_in;
  logic          sec_wrap, min_wrap, hour_wrap;

  assign sec_cur  = data_ch[7:0];
  assign min_cur  = data_ch[15:8];
  assign hour_cur = data_ch[23:16];
  assign sec_in   = setup_data[7:0];
  assign min_in   = setup_data[15:8];
  assign hour_in  = setup_data[23:16];

  assign freeze   = (rezhim == MODE_SETUP);
  assign load_ev  = setup_imp && !setup_prev;
  assign tick_due = (presc == PRESC_MAX);

  // Full carry chain in one step so 23:59:59 rolls straight to 00:00:00.
  always_comb begin
    sec_wrap  = (sec_cur >= 8'd59);
    min_wrap  = (min_cur >= 8'd59);
    hour_wrap = (hour_cur >= 8'd23);
    time_next = data_ch;
    time_next[7:0] = sec_wrap ? 8'd0 : sec_cur + 8'd1;
    if (sec_wrap) begin
      time_next[15:8] = min_wrap ? 8'd0 : min_cur + 8'd1;
      if (min_wrap) begin
        time_next[23:16] = hour_wrap ? 8'd0 : hour_cur + 8'd1;
      end
    end
  end

`ifdef CHASY_LOAD_CHECK_EN
  logic fields_ok;
  logic load_rej;

  assign fields_ok  = (sec_in <= 8'd59) && (min_in <= 8'd59) && (hour_in <= 8'd23);
  assign load_apply = load_ev && fields_ok;
  assign load_rej   = load_ev && !fields_ok;
  assign load_val   = setup_data;
  // A rejected load holds time and prescaler for that cycle.
  assign count_en   = !freeze && !load_rej;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load_rej;
    end
  end
`else
  assign load_apply = load_ev;
  assign load_val   = {(hour_in > 8'd23) ? 8'd0 : hour_in,
                       (min_in  > 8'd59) ? 8'd0 : min_in,
                       (sec_in  > 8'd59) ? 8'd0 : sec_in};
  assign count_en   = !freeze;
  assign load_err   = 1'b0;
`endif

  // Load has priority over a due second, so a coincident tick is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      setup_prev <= 1'b0;
      data_ch    <= '0;
      sec_tick   <= 1'b0;
    end else begin
      setup_prev <= setup_imp;
      sec_tick   <= 1'b0;
      if (load_apply) begin
        data_ch <= load_val;
        presc   <= '0;
      end else if (count_en) begin
        if (tick_due) begin
          presc    <= '0;
          data_ch  <= time_next;
          sec_tick <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter at CLK_FREQ=4: stimulus queues cycle-tagged expectations, a negedge monitor compares them.
// Expected load-check behaviour follows CHASY_LOAD_CHECK_EN when it is defined for the build.
module tb_time_counter;

`ifdef CHASY_LOAD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [1:0]  rezhim;
  logic [23:0] setup_data;
  logic        setup_imp;
  logic [23:0] data_ch;
  logic        sec_tick;
  logic        load_err;

  typedef struct {
    int          cyc;
    logic [23:0] data;
    logic        tick;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  time_counter #(.CLK_FREQ(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .rezhim     (rezhim),
    .setup_data (setup_data),
    .setup_imp  (setup_imp),
    .data_ch    (data_ch),
    .sec_tick   (sec_tick),
    .load_err   (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Queue the outputs expected once 'off' more rising edges have passed.
  task automatic expect_at(input int off, input logic [23:0] d, input logic t, input logic e,
                           input string nm);
    exp_t x;
    x.cyc  = cyc + off;
    x.data = d;
    x.tick = t;
    x.err  = e;
    x.name = $sformatf("%s@%0d", nm, off);
    exp_q.push_back(x);
  endtask

  task automatic apply_stimulus(input logic [1:0] rz, input logic imp, input logic [23:0] d,
                                input int n);
    rezhim     = rz;
    setup_imp  = imp;
    setup_data = d;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_output(input exp_t x);
    if (x.cyc != cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s expectation sampled late: cycle %0d required %0d", x.name, cyc, x.cyc);
    end
    checks++;
    if (data_ch !== x.data) begin
      errors++;
      $display("[TB] FAIL %s data_ch got %06h want %06h", x.name, data_ch, x.data);
    end
    checks++;
    if (sec_tick !== x.tick) begin
      errors++;
      $display("[TB] FAIL %s sec_tick got %b want %b", x.name, sec_tick, x.tick);
    end
    checks++;
    if (load_err !== x.err) begin
      errors++;
      $display("[TB] FAIL %s load_err got %b want %b", x.name, load_err, x.err);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t x;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      x = exp_q.pop_front();
      check_output(x);
    end
  end

  initial begin
    reset      = 1'b1;
    rezhim     = 2'd0;
    setup_imp  = 1'b0;
    setup_data = 24'h0;
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    expect_at(0, 24'h0, 1'b0, 1'b0, "reset_state");
    apply_stimulus(2'd0, 1'b0, 24'h0, 1);

    // Free run from reset: tick every 4th edge, 00:00:03 after 12.
    reset = 1'b1;
    for (int o = 1; o <= 12; o++)
      expect_at(o, 24'(o / 4), (o % 4) == 0, 1'b0, "free_run");
    apply_stimulus(2'd0, 1'b0, 24'h0, 12);

    // 23:59:58 rolls through 23:59:59 straight to 00:00:00.
    for (int o = 1; o <= 9; o++)
      expect_at(o, (o < 5) ? 24'h173B3A : (o < 9) ? 24'h173B3B : 24'h000000,
                (o == 5) || (o == 9), 1'b0, "midnight_wrap");
    apply_stimulus(2'd0, 1'b1, 24'h173B3A, 1);
    apply_stimulus(2'd0, 1'b0, 24'h173B3A, 8);

    // Held-high load request acts once.
    for (int o = 1; o <= 10; o++)
      expect_at(o, (o < 5) ? 24'h010203 : (o < 9) ? 24'h010204 : 24'h010205,
                (o == 5) || (o == 9), 1'b0, "held_load");
    apply_stimulus(2'd0, 1'b1, 24'h010203, 10);

    // Load lands on the edge a tick is due; prescaler is 3 after two more edges.
    apply_stimulus(2'd0, 1'b0, 24'h010203, 2);
    expect_at(0, 24'h010205, 1'b0, 1'b0, "load_vs_tick_pre");
    for (int o = 1; o <= 5; o++)
      expect_at(o, (o < 5) ? 24'h0A0B0C : 24'h0A0B0D, o == 5, 1'b0, "load_vs_tick");
    apply_stimulus(2'd0, 1'b1, 24'h0A0B0C, 1);
    apply_stimulus(2'd0, 1'b0, 24'h0A0B0C, 4);

    // Setup mode freezes counting but accepts a load.
    for (int o = 1; o <= 20; o++)
      expect_at(o, (o <= 10) ? 24'h0A0B0D : 24'h0C0000, 1'b0, 1'b0, "freeze");
    apply_stimulus(2'd3, 1'b0, 24'h0A0B0C, 10);
    apply_stimulus(2'd3, 1'b1, 24'h0C0000, 1);
    apply_stimulus(2'd3, 1'b0, 24'h0C0000, 9);
    for (int o = 1; o <= 4; o++)
      expect_at(o, (o < 4) ? 24'h0C0000 : 24'h0C0001, o == 4, 1'b0, "resume");
    apply_stimulus(2'd0, 1'b0, 24'h0C0000, 4);

    // Out-of-range load 24:60:00.
    for (int o = 1; o <= 5; o++)
      expect_at(o, (o < 5) ? (CHK ? 24'h0C0001 : 24'h000000) : (CHK ? 24'h0C0002 : 24'h000001),
                o == 5, (o == 1) ? CHK : 1'b0, "bad_load");
    apply_stimulus(2'd0, 1'b1, 24'h183C00, 1);
    apply_stimulus(2'd0, 1'b0, 24'h183C00, 4);

    // Reset mid-second with a load request pending; request counts as a load on release.
    apply_stimulus(2'd0, 1'b0, 24'h183C00, 2);
    reset      = 1'b0;
    setup_imp  = 1'b1;
    setup_data = 24'h050607;
    for (int o = 0; o <= 2; o++)
      expect_at(o, 24'h0, 1'b0, 1'b0, "async_reset");
    apply_stimulus(2'd0, 1'b1, 24'h050607, 2);
    reset = 1'b1;
    for (int o = 1; o <= 5; o++)
      expect_at(o, (o < 5) ? 24'h050607 : 24'h050608, o == 5, 1'b0, "load_at_release");
    apply_stimulus(2'd0, 1'b1, 24'h050607, 5);

    for (int w = 0; w < 50 && exp_q.size() > 0; w++) @(posedge clock);
    @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter: CLK_FREQ, 50000000, clock cycles per second, legal range 2 or more.
REQ-002 Port: clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: rezhim  input  2  operating mode; value 3 is setup mode.
REQ-005 Port: setup_data  input  24  load value: [7:0] seconds, [15:8] minutes, [23:16] hours, binary.
REQ-006 Port: setup_imp  input  1  load request; level signal, acted on at its rising edge.
REQ-007 Port: data_ch  output  24  current time, same field layout as setup_data.
REQ-008 Port: sec_tick  output  1  one-cycle pulse on each counted second.
REQ-009 Port: load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-010 The prescaler SHALL count 0..CLK_FREQ-1 and wrap to 0.
- sec_tick asserts for exactly the cycle after the prescaler is at CLK_FREQ-1.
REQ-011 On each second, data_ch SHALL advance in the same cycle as sec_tick is registered:
- seconds 0..59, wrap to 0 with a carry into minutes;
- minutes 0..59, wrap to 0 with a carry into hours;
- hours 0..23, wrap to 0.
REQ-012 23:59:59 SHALL advance to 00:00:00 in a single second; no intermediate value SHALL be visible.
REQ-013 While rezhim==3, the prescaler, seconds counting and sec_tick SHALL be frozen (sec_tick=0).
- Counting SHALL resume from the frozen prescaler value when rezhim leaves 3.
REQ-014 setup_imp SHALL be edge-detected against its registered previous value.
- A load event is setup_imp==1 with previous==0.
- A held-high setup_imp SHALL produce exactly one load event.
REQ-015 On a load event, data_ch SHALL take setup_data at that clock edge, so the new value is visible the next cycle.
- The prescaler SHALL clear to 0 at the same edge.
REQ-016 Load events SHALL be honoured regardless of rezhim.
REQ-017 When a load event coincides with a second boundary, the load SHALL win:
- data_ch = setup_data, no increment, sec_tick = 0 that cycle.
REQ-018 Field widths SHALL be 8 bits; increments and comparisons SHALL use unsigned arithmetic.

Reset
REQ-019 Asserting reset SHALL immediately (asynchronously) force:
- data_ch = 0, sec_tick = 0, load_err = 0;
- prescaler = 0, setup_imp history = 0.
REQ-020 Reset SHALL take effect mid-second and mid-load.
REQ-021 After release, the first second SHALL occur CLK_FREQ cycles later.
REQ-022 If setup_imp is high at reset release, that SHALL count as a load event, since the history is 0.

Configuration
REQ-023 With macro CHASY_LOAD_CHECK_EN defined, a load event with seconds>59, minutes>59 or hours>23 SHALL:
- leave data_ch and the prescaler unchanged;
- pulse load_err for one cycle.
REQ-024 Without CHASY_LOAD_CHECK_EN:
- load_err SHALL be tied to 0;
- each out-of-range field SHALL load as 0 while in-range fields load normally.

Verification
REQ-025 CLK_FREQ=4, rezhim=0, after reset: sec_tick every 4th cycle; data_ch reads 00:00:03 after 12 cycles.
REQ-026 Load 23:59:58 (setup_data=0x173B3A), then run 8 cycles: data_ch = 0x000000; hours/minutes never show intermediate values.
REQ-027 setup_imp held high 10 cycles with setup_data=0x010203: exactly one load, then data_ch advances 0x010203 -> 0x010204 four cycles later.
REQ-028 Load asserted in the cycle a tick is due: data_ch = setup_data, no sec_tick, next tick 4 cycles later.
REQ-029 rezhim=3 for 20 cycles: data_ch constant, sec_tick 0; load 0x0C0000 during freeze is accepted.
REQ-030 setup_data=0x183C00:
- with CHASY_LOAD_CHECK_EN: data_ch unchanged and load_err pulses once;
- without it: data_ch = 0x000000 and load_err stays 0.
- Reset asserted mid-count: all outputs 0 immediately.
